// File: rtl/rv_go_pkg.sv
// Shared definitions for the rv_go data memory path: mem_op encodings and arbiter states.
package rv_go_pkg;

  // mem_op follows the RISC-V funct3 width/sign encoding. Stores reuse the load codes.
  localparam logic [2:0] OpLb  = 3'b000;
  localparam logic [2:0] OpLh  = 3'b001;
  localparam logic [2:0] OpLw  = 3'b010;
  localparam logic [2:0] OpLbu = 3'b100;
  localparam logic [2:0] OpLhu = 3'b101;
  localparam logic [2:0] OpSb  = 3'b000;
  localparam logic [2:0] OpSh  = 3'b001;
  localparam logic [2:0] OpSw  = 3'b010;

  // Value driven on ram_op when nobody owns the RAM.
  localparam logic [2:0] OpIdle = 3'b000;

  typedef enum logic {
    StArb,
    StLocked
  } arb_state_t;

endpackage

// File: rtl/data_ram_arbiter.sv
// Two-port arbiter in front of the single-port data RAM: core (C) has fixed priority,
// the loader/DMA port (D) gets a starvation guard and an optional burst lock.
module data_ram_arbiter
  import rv_go_pkg::*;
#(
  parameter int unsigned AW            = 32,
  parameter int unsigned DW            = 32,
  parameter int unsigned MAX_CORE_WINS = 4,
  parameter int unsigned LOCK_MAX      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [2:0]    core_op,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_stall,
  output logic [DW-1:0] core_rdata,
  output logic          core_rvalid,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [2:0]    dma_op,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  input  logic          dma_lock,
  output logic          dma_gnt,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_rvalid,
  output logic          ram_wen_n,
  output logic [2:0]    ram_op,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam int unsigned SW = $clog2(MAX_CORE_WINS + 1);
  localparam int unsigned LW = $clog2(LOCK_MAX + 1);
  localparam logic [SW-1:0] StarveMax = SW'(MAX_CORE_WINS);
  localparam logic [LW-1:0] LockMax   = LW'(LOCK_MAX);

  arb_state_t    state_q, state_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic [LW-1:0] lock_inc;
  logic [1:0]    rd_owner_q;  // {core, dma} read granted last cycle
  logic          core_gnt;

  // Grant decision; forced idle while reset is asserted.
  always_comb begin
    core_gnt = 1'b0;
    dma_gnt  = 1'b0;
    if (rst) begin
      unique case (state_q)
        StArb: begin
          if (dma_req && (!core_req || starve_cnt_q == StarveMax)) dma_gnt = 1'b1;
          else if (core_req) core_gnt = 1'b1;
        end
        StLocked: begin
          if (dma_req) dma_gnt = 1'b1;
          else if (core_req) core_gnt = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // RAM port mux following the grant; idle values when nobody is granted.
  always_comb begin
    ram_wen_n = 1'b1;
    ram_op    = OpIdle;
    ram_addr  = '0;
    ram_din   = '0;
    if (core_gnt) begin
      ram_wen_n = ~core_we;
      ram_op    = core_op;
      ram_addr  = core_addr;
      ram_din   = core_wdata;
    end else if (dma_gnt) begin
      ram_wen_n = ~dma_we;
      ram_op    = dma_op;
      ram_addr  = dma_addr;
      ram_din   = dma_wdata;
    end
  end

  assign core_stall  = core_req & ~core_gnt;
  assign core_rvalid = rd_owner_q[1];
  assign dma_rvalid  = rd_owner_q[0];
  // Read data is shared; consumers qualify it with their own rvalid.
  assign core_rdata  = ram_dout;
  assign dma_rdata   = ram_dout;

  assign lock_inc = lock_cnt_q + LW'(1);

  // Next-state for the lock FSM and the starvation / lock counters.
  always_comb begin
    state_d      = state_q;
    lock_cnt_d   = lock_cnt_q;
    starve_cnt_d = starve_cnt_q;

    if (!dma_req || dma_gnt) starve_cnt_d = '0;
    else if (core_gnt && starve_cnt_q != StarveMax) starve_cnt_d = starve_cnt_q + SW'(1);

    unique case (state_q)
      StArb: begin
        // The entering grant is the first locked grant of the burst.
        if (dma_gnt && dma_lock && LOCK_MAX > 1) begin
          state_d    = StLocked;
          lock_cnt_d = LW'(1);
        end
      end
      StLocked: begin
        // The exit cycle still grants D when it requests.
        if (!dma_lock || !dma_req || lock_inc >= LockMax) begin
          state_d    = StArb;
          lock_cnt_d = '0;
        end else if (dma_gnt) begin
          lock_cnt_d = lock_inc;
        end
      end
      default: begin
        state_d    = StArb;
        lock_cnt_d = '0;
      end
    endcase
  end

  // State, counters and read-owner registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StArb;
      starve_cnt_q <= '0;
      lock_cnt_q   <= '0;
      rd_owner_q   <= 2'b00;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
      rd_owner_q   <= {core_gnt & ~core_we, dma_gnt & ~dma_we};
    end
  end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed bench for data_ram_arbiter with a simple synchronous RAM model attached.
module tb_data_ram_arbiter;
  import rv_go_pkg::*;

  logic        clk;
  logic        rst;
  logic        core_req, core_we;
  logic [2:0]  core_op;
  logic [31:0] core_addr, core_wdata;
  logic        core_stall;
  logic [31:0] core_rdata;
  logic        core_rvalid;
  logic        dma_req, dma_we, dma_lock;
  logic [2:0]  dma_op;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_gnt;
  logic [31:0] dma_rdata;
  logic        dma_rvalid;
  logic        ram_wen_n;
  logic [2:0]  ram_op;
  logic [31:0] ram_addr, ram_din, ram_dout;

  logic [31:0] ram_mem [0:255];

  int n_cmp = 0;
  int n_bad = 0;

  data_ram_arbiter #(
    .AW(32), .DW(32), .MAX_CORE_WINS(4), .LOCK_MAX(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_op    (core_op),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_stall (core_stall),
    .core_rdata (core_rdata),
    .core_rvalid(core_rvalid),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_op     (dma_op),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_lock   (dma_lock),
    .dma_gnt    (dma_gnt),
    .dma_rdata  (dma_rdata),
    .dma_rvalid (dma_rvalid),
    .ram_wen_n  (ram_wen_n),
    .ram_op     (ram_op),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-wide synchronous RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (!ram_wen_n) ram_mem[ram_addr[9:2]] <= ram_din;
    ram_dout <= ram_mem[ram_addr[9:2]];
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no_finish want finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s: got %b want %b", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  task automatic idle_inputs();
    core_req = 1'b0; core_we = 1'b0; core_op = OpLw; core_addr = '0; core_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_op = OpLw; dma_addr = '0; dma_wdata = '0;
    dma_lock = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic dma_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    idle_inputs();
    dma_req = 1'b1; dma_we = 1'b1; dma_op = OpSw; dma_addr = a; dma_wdata = d;
    #1 chk1("dma_wr_gnt", dma_gnt, 1'b1);
  endtask

  logic [5:0] pat2;

  initial begin
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    chk1("rst_core_rvalid", core_rvalid, 1'b0);
    chk1("rst_dma_rvalid", dma_rvalid, 1'b0);
    chk1("rst_wen_n", ram_wen_n, 1'b1);
    chk32("rst_ram_addr", ram_addr, 32'h0);
    rst = 1'b1;

    // Core-only load.
    dma_write(32'h10, 32'hDEADBEEF);
    @(negedge clk);
    idle_inputs();
    chk1("t1_wr_no_rvalid", dma_rvalid, 1'b0);
    core_req = 1'b1; core_op = OpLw; core_addr = 32'h10;
    #1;
    chk1("t1_stall", core_stall, 1'b0);
    chk32("t1_ram_addr", ram_addr, 32'h10);
    chk32("t1_ram_op", 32'(ram_op), 32'(OpLw));
    chk1("t1_wen_n", ram_wen_n, 1'b1);
    @(negedge clk);
    idle_inputs();
    chk1("t1_rvalid", core_rvalid, 1'b1);
    chk32("t1_rdata", core_rdata, 32'hDEADBEEF);
    chk1("t1_dma_rvalid", dma_rvalid, 1'b0);
    @(negedge clk);
    chk1("t1_rvalid_drop", core_rvalid, 1'b0);

    // Collision: expect C,C,C,C,D,C.
    pulse_reset();
    pat2 = 6'b010000;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) @(negedge clk);
      core_req = 1'b1; core_we = 1'b0; core_op = OpLw; core_addr = 32'h10;
      dma_req = 1'b1; dma_we = 1'b1; dma_op = OpSw; dma_addr = 32'h40; dma_wdata = 32'(c);
      #1;
      chk1("t2_dma_gnt", dma_gnt, pat2[c-1]);
      chk1("t2_stall", core_stall, pat2[c-1]);
      chk32("t2_ram_addr", ram_addr, pat2[c-1] ? 32'h40 : 32'h10);
    end

    // Locked burst of 8 writes with the core requesting throughout.
    pulse_reset();
    for (int c = 1; c <= 13; c++) begin
      int w;
      if (c > 1) @(negedge clk);
      w = (c < 5) ? 0 : c - 5;
      core_req = 1'b1; core_we = 1'b0; core_op = OpLw; core_addr = 32'h80;
      if (c <= 12) begin
        dma_req = 1'b1; dma_we = 1'b1; dma_op = OpSw; dma_lock = (c != 12);
        dma_addr = 32'h100 + 32'(w * 4); dma_wdata = 32'hA000_0000 + 32'(w);
      end else begin
        dma_req = 1'b0; dma_lock = 1'b0; dma_we = 1'b0;
      end
      #1;
      chk1("t3_dma_gnt", dma_gnt, (c >= 5 && c <= 12));
      chk1("t3_stall", core_stall, (c >= 5 && c <= 12));
    end
    @(negedge clk);
    idle_inputs();
    for (int i = 0; i < 8; i++) chk32("t3_ram_word", ram_mem[64+i], 32'hA000_0000 + 32'(i));

    // Lock limit: 16 locked grants, then the core gets through.
    pulse_reset();
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) @(negedge clk);
      core_req = (c >= 2); core_we = 1'b0; core_op = OpLw; core_addr = 32'h80;
      dma_req = 1'b1; dma_we = 1'b1; dma_lock = 1'b1; dma_op = OpSw;
      dma_addr = 32'h200; dma_wdata = 32'(c);
      #1;
      chk1("t4_dma_gnt", dma_gnt, (c <= 16));
      chk1("t4_stall", core_stall, (c >= 2 && c <= 16));
    end

    // Back-to-back reads by different owners.
    pulse_reset();
    dma_write(32'h20, 32'h1111_2222);
    dma_write(32'h24, 32'h3333_4444);
    @(negedge clk);
    idle_inputs();
    dma_req = 1'b1; dma_we = 1'b0; dma_op = OpLw; dma_addr = 32'h20;
    #1 chk1("t5_dma_gnt", dma_gnt, 1'b1);
    @(negedge clk);
    idle_inputs();
    chk1("t5_dma_rvalid", dma_rvalid, 1'b1);
    chk32("t5_dma_rdata", dma_rdata, 32'h1111_2222);
    chk1("t5_core_rvalid0", core_rvalid, 1'b0);
    core_req = 1'b1; core_op = OpLw; core_addr = 32'h24;
    #1 chk1("t5_stall", core_stall, 1'b0);
    @(negedge clk);
    idle_inputs();
    chk1("t5_core_rvalid", core_rvalid, 1'b1);
    chk32("t5_core_rdata", core_rdata, 32'h3333_4444);
    chk1("t5_dma_rvalid0", dma_rvalid, 1'b0);

    // Reset in the middle of a locked read burst.
    pulse_reset();
    @(negedge clk);
    idle_inputs();
    dma_req = 1'b1; dma_we = 1'b0; dma_lock = 1'b1; dma_op = OpLw; dma_addr = 32'h20;
    #1 chk1("t6_gnt1", dma_gnt, 1'b1);
    @(negedge clk);
    core_req = 1'b1; core_op = OpLw; core_addr = 32'h24;
    dma_addr = 32'h24;
    #1;
    chk1("t6_gnt2", dma_gnt, 1'b1);
    chk1("t6_stall2", core_stall, 1'b1);
    @(negedge clk);
    chk1("t6_rvalid_pre", dma_rvalid, 1'b1);
    rst = 1'b0;
    #1;
    chk1("t6_rvalid_rst", dma_rvalid, 1'b0);
    chk1("t6_core_rvalid_rst", core_rvalid, 1'b0);
    chk1("t6_gnt_rst", dma_gnt, 1'b0);
    chk1("t6_wen_rst", ram_wen_n, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk1("t6_core_wins", core_stall, 1'b0);
    chk1("t6_dma_waits", dma_gnt, 1'b0);
    chk32("t6_ram_addr", ram_addr, 32'h24);
    @(negedge clk);
    idle_inputs();
    chk1("t6_core_rvalid", core_rvalid, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
